// File: rtl/thumb_fetch_unit_pkg.sv
// rtl/thumb_fetch_unit_pkg.sv - shared types and constants for the Thumb fetch unit
//
// Contents:
//   fetch_state_t  fetch FSM encoding (IDLE / WAIT / FLUSH)
//   QDEPTH_DEF     default halfword queue depth
//   HW_W, ADDR_W   halfword and address widths
//   OCC_W, PTR_W   queue occupancy and pointer widths
package thumb_fetch_unit_pkg;

  localparam int QDEPTH_DEF = 4;
  localparam int HW_W       = 16;
  localparam int ADDR_W     = 32;
  localparam int OCC_W      = 3;
  localparam int PTR_W      = 2;

  // IDLE : no request outstanding
  // WAIT : request outstanding, response will be pushed
  // FLUSH: request outstanding, response will be dropped
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/thumb_hw_queue.sv
// rtl/thumb_hw_queue.sv - 4-entry halfword FIFO with per-entry PC
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_flush                 empty the queue (wins over push and pop)
//   i_push_cnt              number of halfwords pushed this cycle (0..2)
//   i_push_hw0/i_push_pc0   first pushed halfword and its address
//   i_push_hw1/i_push_pc1   second pushed halfword and its address
//   i_pop                   remove the head entry
//   o_head_hw/o_head_pc     registered head entry
//   o_occ                   number of valid entries
module thumb_hw_queue
  import thumb_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic [1:0]        i_push_cnt,
  input  logic [HW_W-1:0]   i_push_hw0,
  input  logic [ADDR_W-1:0] i_push_pc0,
  input  logic [HW_W-1:0]   i_push_hw1,
  input  logic [ADDR_W-1:0] i_push_pc1,
  input  logic              i_pop,
  output logic [HW_W-1:0]   o_head_hw,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [OCC_W-1:0]  o_occ
);

  localparam logic [ADDR_W-1:0] PC_RST = {RESET_PC[ADDR_W-1:1], 1'b0};

  logic [HW_W-1:0]   r_hw [0:QDEPTH_DEF-1];
  logic [ADDR_W-1:0] r_pc [0:QDEPTH_DEF-1];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_occ;

  logic [PTR_W-1:0]  w_wr1;
  logic              w_pop;

  assign w_wr1 = r_wr_ptr + 2'd1;
  // Popping an empty queue is ignored so occupancy can never underflow.
  assign w_pop = i_pop && (r_occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH_DEF; i++) begin
        r_hw[i] <= '0;
        r_pc[i] <= PC_RST;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push_cnt != 2'd0) begin
        r_hw[r_wr_ptr] <= i_push_hw0;
        r_pc[r_wr_ptr] <= i_push_pc0;
      end
      if (i_push_cnt == 2'd2) begin
        r_hw[w_wr1] <= i_push_hw1;
        r_pc[w_wr1] <= i_push_pc1;
      end
      r_wr_ptr <= r_wr_ptr + i_push_cnt;
      r_rd_ptr <= r_rd_ptr + {1'b0, w_pop};
      r_occ    <= r_occ + {1'b0, i_push_cnt} - {2'b00, w_pop};
    end
  end

  // Head comes straight from storage registers; no path from push inputs.
  assign o_head_hw = r_hw[r_rd_ptr];
  assign o_head_pc = r_pc[r_rd_ptr];
  assign o_occ     = r_occ;

endmodule

// File: rtl/thumb_fetch_unit.sv
// rtl/thumb_fetch_unit.sv - Thumb instruction fetch unit with halfword queue
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  word-aligned fetch request, held until imem_ack
//   imem_ack/imem_rdata fetch completion and little-endian data word
//   redirect/redirect_pc  branch/exception redirect to a halfword address
//   thumb_code/code_pc  queue head halfword and its address
//   code_valid/code_ready  head handshake towards the decoder
module thumb_fetch_unit
  import thumb_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = QDEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [15:0] thumb_code,
  output logic [31:0] code_pc,
  output logic        code_valid,
  input  logic        code_ready
);

  localparam logic [31:0]      FETCH_RST = {RESET_PC[31:2], 2'b00};
  // A fetch is only started when a full word is guaranteed to fit.
  localparam logic [OCC_W-1:0] ISSUE_MAX = OCC_W'(QDEPTH - 2);

  fetch_state_t r_state;
  fetch_state_t w_state_n;

  logic        r_run;
  logic [31:0] r_fetch_addr;
  logic        r_offset;
  logic [31:0] r_req_addr;
  logic        r_req_off;

  logic             w_req;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_push_cnt;
  logic [OCC_W-1:0] w_occ;
  logic             w_unused_pc0;

  assign w_unused_pc0 = redirect_pc[0];

  always_comb begin
    w_state_n = r_state;
    w_req     = 1'b0;
    w_issue   = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_run holds off the first request until one edge after reset release.
        if (r_run && !redirect && (w_occ <= ISSUE_MAX)) begin
          w_req     = 1'b1;
          w_issue   = 1'b1;
          w_state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (redirect) begin
          w_state_n = imem_ack ? ST_IDLE : ST_FLUSH;
        end else if (imem_ack) begin
          w_push    = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_run        <= 1'b0;
      r_fetch_addr <= FETCH_RST;
      r_offset     <= RESET_PC[1];
      r_req_addr   <= FETCH_RST;
      r_req_off    <= RESET_PC[1];
    end else begin
      r_state <= w_state_n;
      r_run   <= 1'b1;
      if (w_issue) begin
        r_req_addr <= r_fetch_addr;
        r_req_off  <= r_offset;
      end
      if (redirect) begin
        r_fetch_addr <= {redirect_pc[31:2], 2'b00};
        r_offset     <= redirect_pc[1];
      end else if (w_push) begin
        // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
        r_fetch_addr <= r_req_addr + 32'd4;
        r_offset     <= 1'b0;
      end
    end
  end

  // The outstanding address is kept separately so a redirect during the
  // request can move the fetch pointer without disturbing imem_addr.
  assign imem_req  = w_req;
  assign imem_addr = (r_state == ST_IDLE) ? r_fetch_addr : r_req_addr;

  assign w_push_cnt = w_push ? (r_req_off ? 2'd1 : 2'd2) : 2'd0;
  assign w_pop      = code_valid && code_ready && !redirect;
  assign code_valid = (w_occ != '0);

  thumb_hw_queue #(
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (redirect),
    .i_push_cnt (w_push_cnt),
    .i_push_hw0 (r_req_off ? imem_rdata[31:16] : imem_rdata[15:0]),
    .i_push_pc0 (r_req_off ? (r_req_addr + 32'd2) : r_req_addr),
    .i_push_hw1 (imem_rdata[31:16]),
    .i_push_pc1 (r_req_addr + 32'd2),
    .i_pop      (w_pop),
    .o_head_hw  (thumb_code),
    .o_head_pc  (code_pc),
    .o_occ      (w_occ)
  );

endmodule
